// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache with true-LRU replacement,
// multi-word block fill, full-cache flush and a saturating miss counter.
//
// Ports
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   imemREN, imemaddr  fetch request and word-aligned byte address from the CPU
//   ihit, imemload     combinational hit flag and instruction (0 when no hit)
//   flush              one-cycle pulse invalidating every line
//   iREN, iaddr        registered read request/word address to the controller
//   iwait, iload       controller busy flag and read data
//   miss_count         number of fills started, saturating
module icache_assoc #(
    parameter int SETS     = 8,
    parameter int WAYS     = 2,
    parameter int BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] miss_count
);

    localparam int BO_W  = $clog2(BLKWORDS);
    localparam int IX_W  = $clog2(SETS);
    localparam int TAG_W = 30 - BO_W - IX_W;
    localparam int CNT_W = (BO_W > 0) ? BO_W : 1;
    localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state;
    logic              valid [SETS][WAYS];
    logic [TAG_W-1:0]  tags  [SETS][WAYS];
    logic [31:0]       data  [SETS][WAYS][BLKWORDS];
    // Age 0 = most recently used, WAYS-1 = least recently used.
    logic [AGE_W-1:0]  age   [SETS][WAYS];

    logic [CNT_W-1:0]  cnt;
    logic [TAG_W-1:0]  fill_tag;
    logic [IX_W-1:0]   fill_idx;
    logic [AGE_W-1:0]  fill_way;

    logic [29:0]       waddr;
    logic [TAG_W-1:0]  req_tag;
    logic [IX_W-1:0]   req_idx;
    logic [CNT_W-1:0]  req_off;
    logic              hit;
    logic [AGE_W-1:0]  hit_way;
    logic [AGE_W-1:0]  victim;
    logic              fill_word;
    logic              fill_last;
    logic              touch_en;
    logic [IX_W-1:0]   touch_idx;
    logic [AGE_W-1:0]  touch_way;
    logic              unused_bits;

    assign unused_bits = ^imemaddr[1:0];
    assign waddr       = imemaddr[31:2];
    assign req_tag     = waddr[29 -: TAG_W];
    assign req_idx     = waddr[BO_W +: IX_W];

    generate
        if (BO_W > 0) begin : g_off
            assign req_off = waddr[CNT_W-1:0];
        end else begin : g_no_off
            assign req_off = '0;
        end
    endgenerate

    // Word address of a block word; the count term is always 0 for one-word blocks.
    function automatic logic [31:0] fill_addr(input logic [TAG_W-1:0] t,
                                              input logic [IX_W-1:0]  i,
                                              input logic [CNT_W-1:0] c);
        logic [29:0] w;
        w = (30'(t) << (BO_W + IX_W)) | (30'(i) << BO_W) | 30'(c);
        return {w, 2'b00};
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[req_idx][w] && tags[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
    end

    // Lowest invalid way first; otherwise the least recently used way.
    always_comb begin
        logic found;
        found  = 1'b0;
        victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid[req_idx][w]) begin
                victim = AGE_W'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age[req_idx][w] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
            end
        end
    end

    assign ihit      = (state == IDLE) && imemREN && hit;
    assign imemload  = ihit ? data[req_idx][hit_way][req_off] : 32'h0;
    assign fill_word = (state == FILL) && !flush && !iwait;
    assign fill_last = fill_word && (cnt == CNT_W'(BLKWORDS - 1));

    always_comb begin
        touch_en  = 1'b0;
        touch_idx = req_idx;
        touch_way = hit_way;
        if (ihit) begin
            touch_en = 1'b1;
        end else if (fill_last) begin
            touch_en  = 1'b1;
            touch_idx = fill_idx;
            touch_way = fill_way;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            cnt        <= '0;
            miss_count <= '0;
            iREN       <= 1'b0;
            iaddr      <= '0;
            fill_tag   <= '0;
            fill_idx   <= '0;
            fill_way   <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    age[s][w]   <= AGE_W'(w);
                end
            end
        end else begin
            if (touch_en) begin
                for (int v = 0; v < WAYS; v++) begin
                    if (age[touch_idx][v] < age[touch_idx][touch_way])
                        age[touch_idx][v] <= age[touch_idx][v] + AGE_W'(1);
                end
                age[touch_idx][touch_way] <= '0;
            end
            case (state)
                IDLE: begin
                    if (flush) begin
                        for (int s = 0; s < SETS; s++)
                            for (int w = 0; w < WAYS; w++) valid[s][w] <= 1'b0;
                    end else if (imemREN && !hit) begin
                        // Victim is invalidated up front so an aborted fill never leaves stale data visible.
                        valid[req_idx][victim] <= 1'b0;
                        fill_tag <= req_tag;
                        fill_idx <= req_idx;
                        fill_way <= victim;
                        cnt      <= '0;
                        iREN     <= 1'b1;
                        iaddr    <= fill_addr(req_tag, req_idx, '0);
                        state    <= FILL;
                        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
                    end
                end
                FILL: begin
                    if (flush) begin
                        for (int s = 0; s < SETS; s++)
                            for (int w = 0; w < WAYS; w++) valid[s][w] <= 1'b0;
                        iREN  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (fill_last) begin
                        valid[fill_idx][fill_way] <= 1'b1;
                        iREN  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (fill_word) begin
                        cnt   <= cnt + CNT_W'(1);
                        iaddr <= fill_addr(fill_tag, fill_idx, cnt + CNT_W'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage carries no reset; validity is tracked by the valid bits alone.
    always_ff @(posedge CLK) begin
        if (fill_word) data[fill_idx][fill_way][cnt] <= iload;
        if (fill_last) tags[fill_idx][fill_way] <= fill_tag;
    end

endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: directed stimulus for icache_assoc with a cycle-level
// behavioural model (block residency per set with recency stamps) checked
// on every falling edge, plus hand-computed literal expectations.
module tb_icache_assoc;

    localparam int SETS     = 8;
    localparam int WAYS     = 2;
    localparam int BLKWORDS = 2;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] miss_count;

    int n_cmp  = 0;
    int n_fail = 0;
    bit wait_mode = 0;
    int wc = 0;

    icache_assoc #(.SETS(SETS), .WAYS(WAYS), .BLKWORDS(BLKWORDS)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
        .iaddr(iaddr), .iwait(iwait), .iload(iload), .miss_count(miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Backing memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h11;
        if (a == 32'h44) return 32'h22;
        return a ^ 32'h5A00_0000;
    endfunction

    assign iload = iwait ? 32'hBAD0_BAD0 : mem_word(iaddr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid [SETS][WAYS];
    int unsigned m_blk   [SETS][WAYS];
    int          m_stamp [SETS][WAYS];
    int          m_now;
    bit          m_fill;
    int          m_fset, m_fway, m_fcnt;
    int unsigned m_fblk;
    logic [31:0] m_miss;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_stamp[s][w] = -w;
            end
        m_now  = 0;
        m_fill = 0;
        m_fcnt = 0;
        m_miss = 0;
    endtask

    task automatic model_clear_all();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
    endtask

    always @(negedge CLK) begin : scoreboard
        int unsigned blk;
        int          s, hw, v;
        bit          hit;
        if (!nRST) begin
            check("rst_ihit", 32'(ihit), 32'd0);
            check("rst_imemload", imemload, 32'd0);
            check("rst_iREN", 32'(iREN), 32'd0);
            check("rst_iaddr", iaddr, 32'd0);
            check("rst_miss_count", miss_count, 32'd0);
            model_reset();
        end else if (!m_fill) begin
            blk = (imemaddr >> 2) / BLKWORDS;
            s   = int'(blk % SETS);
            hit = 0;
            hw  = 0;
            for (int w = 0; w < WAYS; w++)
                if (m_valid[s][w] && m_blk[s][w] == blk) begin hit = 1; hw = w; end
            hit = hit && imemREN;
            check("idle_ihit", 32'(ihit), 32'(hit));
            check("idle_imemload", imemload, hit ? mem_word(imemaddr) : 32'd0);
            check("idle_iREN", 32'(iREN), 32'd0);
            check("idle_miss_count", miss_count, m_miss);
            if (hit) begin
                m_now = m_now + 1;
                m_stamp[s][hw] = m_now;
            end
            if (flush) begin
                model_clear_all();
            end else if (imemREN && !hit) begin
                v = -1;
                for (int w = 0; w < WAYS; w++)
                    if (v < 0 && !m_valid[s][w]) v = w;
                if (v < 0) begin
                    v = 0;
                    for (int w = 1; w < WAYS; w++)
                        if (m_stamp[s][w] < m_stamp[s][v]) v = w;
                end
                m_valid[s][v] = 0;
                m_fill = 1; m_fset = s; m_fway = v; m_fblk = blk; m_fcnt = 0;
                if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
            end
        end else begin
            check("fill_ihit", 32'(ihit), 32'd0);
            check("fill_imemload", imemload, 32'd0);
            check("fill_iREN", 32'(iREN), 32'd1);
            check("fill_iaddr", iaddr, 32'((m_fblk * BLKWORDS + m_fcnt) * 4));
            check("fill_miss_count", miss_count, m_miss);
            if (flush) begin
                model_clear_all();
                m_fill = 0;
            end else if (!iwait) begin
                m_fcnt++;
                if (m_fcnt == BLKWORDS) begin
                    m_valid[m_fset][m_fway] = 1;
                    m_blk[m_fset][m_fway]   = m_fblk;
                    m_now = m_now + 1;
                    m_stamp[m_fset][m_fway] = m_now;
                    m_fill = 0;
                end
            end
        end
    end

    // Controller wait-state generator: three busy cycles before each word when enabled.
    initial begin
        iwait = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (wait_mode && iREN) begin
                iwait = (wc < 3);
                wc    = (wc < 3) ? wc + 1 : 0;
            end else begin
                iwait = 1'b0;
                wc    = 0;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present a fetch and wait for its hit; returns the number of edges it took.
    task automatic fetch_wait(input logic [31:0] a, output int cyc);
        imemREN  = 1'b1;
        imemaddr = a;
        cyc      = 0;
        #1;
        while (ihit !== 1'b1 && cyc < 64) begin
            @(posedge CLK);
            #2;
            cyc++;
        end
        if (ihit !== 1'b1) check("fetch_timeout", 32'(ihit), 32'd1);
    endtask

    initial begin
        int c;
        nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; flush = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_iREN", 32'(iREN), 32'd0);
        check("reset_ihit", 32'(ihit), 32'd0);
        check("reset_iaddr", iaddr, 32'd0);
        check("reset_miss_count", miss_count, 32'd0);
        nRST = 1'b1;
        step();

        // Cold miss on 0x40
        imemREN = 1'b1; imemaddr = 32'h40;
        #1;
        check("cold_c0_ihit", 32'(ihit), 32'd0);
        @(posedge CLK); #2;
        check("cold_c1_iREN", 32'(iREN), 32'd1);
        check("cold_c1_iaddr", iaddr, 32'h40);
        @(posedge CLK); #2;
        check("cold_c2_iREN", 32'(iREN), 32'd1);
        check("cold_c2_iaddr", iaddr, 32'h44);
        @(posedge CLK); #2;
        check("cold_c3_ihit", 32'(ihit), 32'd1);
        check("cold_c3_imemload", imemload, 32'h11);
        step();
        imemaddr = 32'h44;
        #1;
        check("cold_44_ihit", 32'(ihit), 32'd1);
        check("cold_44_imemload", imemload, 32'h22);
        check("cold_miss_count", miss_count, 32'd1);

        // LRU replacement in set 0
        step(); fetch_wait(32'h80, c); check("lru_80_cycles", c, 3);
        step(); fetch_wait(32'h40, c); check("lru_40_hit_cycles", c, 0);
        step(); fetch_wait(32'hC0, c); check("lru_C0_cycles", c, 3);
        step(); fetch_wait(32'h40, c); check("lru_40_still_hit", c, 0);
        step(); fetch_wait(32'h80, c); check("lru_80_evicted", c, 3);
        check("lru_miss_count", miss_count, 32'd4);

        // Wait states
        step();
        wait_mode = 1;
        fetch_wait(32'h200, c);
        check("wait_cycles", c, 9);
        check("wait_imemload", imemload, 32'h5A00_0200);
        wait_mode = 0;

        // Address change during fill
        step(); flush = 1'b1; imemREN = 1'b0;
        step(); flush = 1'b0; imemREN = 1'b1; imemaddr = 32'h40;
        step(); imemaddr = 32'h100;
        #1;
        check("midfill_ihit", 32'(ihit), 32'd0);
        check("midfill_iaddr", iaddr, 32'h40);
        fetch_wait(32'h100, c); check("midfill_100_cycles", c, 5);
        step(); fetch_wait(32'h40, c); check("midfill_40_filled", c, 0);

        // Flush in IDLE: lookup still served, then the line is gone
        step(); imemaddr = 32'h40; flush = 1'b1;
        #1;
        check("flush_cycle_hit", 32'(ihit), 32'd1);
        step(); flush = 1'b0;
        fetch_wait(32'h40, c); check("flush_40_misses", c, 3);

        // Flush during fill
        step(); imemaddr = 32'h80;
        step(); flush = 1'b1;
        step(); flush = 1'b0; imemREN = 1'b0;
        #1;
        check("flush_fill_iREN", 32'(iREN), 32'd0);
        step(); fetch_wait(32'h40, c); check("flush_fill_40_misses", c, 3);

        // Reset during fill
        step(); imemaddr = 32'h80; imemREN = 1'b1;
        step(); nRST = 1'b0;
        #1;
        check("rstfill_iREN", 32'(iREN), 32'd0);
        check("rstfill_ihit", 32'(ihit), 32'd0);
        check("rstfill_miss_count", miss_count, 32'd0);
        step(); nRST = 1'b1;
        fetch_wait(32'h40, c); check("rstfill_40_misses", c, 3);
        check("rstfill_miss_count_restart", miss_count, 32'd1);

        // Sweep several sets
        for (int i = 0; i < 16; i++) begin
            step();
            fetch_wait(32'(i * 4), c);
        end
        step(); imemREN = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
